// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - two-to-one inst/data arbiter onto a single SRAM-like memory port
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   inst_req/wr/size/addr/wstrb/wdata -> inst_addr_ok, inst_data_ok, inst_rdata
//   data_req/wr/size/addr/wstrb/wdata -> data_addr_ok, data_data_ok, data_rdata
//   mem_req/wr/size/addr/wstrb/wdata  shared request toward the memory bridge
//   mem_addr_ok, mem_data_ok, mem_rdata  memory handshake and read data
//
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration on
// simultaneous requests; without it the data side has fixed priority.
module cpu_sram_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner;       // 0 = inst, 1 = data
    logic   grant_data;  // winner of this cycle's arbitration is the data side
    logic   accept;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;    // 0 = inst, 1 = data

    // On a tie the side that did not win last time goes next.
    always_comb begin
        grant_data = data_req;
        if (inst_req && data_req) begin
            grant_data = ~last_grant;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b0;
        end else if (accept) begin
            last_grant <= grant_data;
        end
    end
`else
    assign grant_data = data_req;
`endif

    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        mem_req      = 1'b0;
        case (state)
            S_IDLE: begin
                // resetn gating keeps addr_ok low while reset holds the FSM in IDLE.
                if (resetn && (inst_req || data_req)) begin
                    accept       = 1'b1;
                    data_addr_ok = grant_data;
                    inst_addr_ok = ~grant_data;
                    state_nxt    = S_ADDR;
                end
            end
            S_ADDR: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (mem_data_ok) begin
                    inst_data_ok = ~owner;
                    data_data_ok = owner;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            owner     <= 1'b0;
            mem_wr    <= 1'b0;
            mem_size  <= 2'd0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner     <= grant_data;
                mem_wr    <= grant_data ? data_wr    : inst_wr;
                mem_size  <= grant_data ? data_size  : inst_size;
                mem_addr  <= grant_data ? data_addr  : inst_addr;
                mem_wstrb <= grant_data ? data_wstrb : inst_wstrb;
                mem_wdata <= grant_data ? data_wdata : inst_wdata;
            end
        end
    end

    // Read data is shared; the owner's data_ok is what qualifies it.
    assign inst_rdata = resetn ? mem_rdata : 32'd0;
    assign data_rdata = resetn ? mem_rdata : 32'd0;

endmodule
